// File: rtl/float_to_exp_index.sv
// Converts an IEEE-754 single-precision value into an exponent-table index
// (integer(value) + 127) through a 2-stage stallable pipeline.
// Define FLOAT_TO_EXP_INDEX_ROUND_EN to round to nearest (ties away from
// zero); the default build truncates toward zero.
module float_to_exp_index #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [11:0]           out_addr,
  output logic                  out_err,
  output logic                  out_inexact,
  output logic [7:0]            err_cnt
);

  logic        en;
  logic [7:0]  exp_f;
  logic [22:0] man_f;
  logic [23:0] sig;
  logic [7:0]  shift;
  logic [23:0] shifted;
  logic [23:0] frac_mask;

  logic [10:0] dec_mag;
  logic        dec_inexact;
  logic        dec_nan;

  logic        s1_valid_d, s1_valid_q;
  logic        s1_sign_d, s1_sign_q;
  logic        s1_nan_d, s1_nan_q;
  logic        s1_inexact_d, s1_inexact_q;
  logic [10:0] s1_mag_d, s1_mag_q;

  logic [11:0] mag_r;
  logic [11:0] res_addr;
  logic        res_err;
  logic        res_inexact;

  logic        out_valid_d, out_valid_q;
  logic [11:0] out_addr_d, out_addr_q;
  logic        out_err_d, out_err_q;
  logic        out_inexact_d, out_inexact_q;
  logic [7:0]  err_cnt_d, err_cnt_q;

  // Stage 1 decode: integer magnitude of |value|, saturated to 11 bits.
  always_comb begin
    en          = !out_valid_q || out_ready;
    exp_f       = in_data[30:23];
    man_f       = in_data[22:0];
    sig         = {1'b1, man_f};
    shift       = 8'd150 - exp_f;
    shifted     = sig >> shift;
    frac_mask   = (24'd1 << shift) - 24'd1;
    dec_mag     = 11'd0;
    dec_inexact = 1'b0;
    dec_nan     = 1'b0;
    if (exp_f == 8'hFF) begin
      dec_nan = 1'b1;
    end else if (exp_f == 8'd0) begin
      dec_inexact = |man_f;
    end else if (exp_f < 8'd127) begin
      dec_inexact = 1'b1;
    end else if (exp_f <= 8'd150) begin
      dec_mag     = (|shifted[23:11]) ? 11'h7FF : shifted[10:0];
      dec_inexact = |(sig & frac_mask);
    end else begin
      dec_mag = 11'h7FF;
    end
  end

`ifdef FLOAT_TO_EXP_INDEX_ROUND_EN
  logic dec_round;
  logic s1_round_d, s1_round_q;

  // Round bit is the first discarded fraction bit; exp 126 means |v| in [0.5,1).
  always_comb begin
    dec_round = 1'b0;
    if (exp_f == 8'd126) begin
      dec_round = 1'b1;
    end else if (exp_f >= 8'd127 && exp_f <= 8'd150 && shift != 8'd0) begin
      dec_round = |(sig & (24'd1 << (shift - 8'd1)));
    end
    s1_round_d = en ? dec_round : s1_round_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_round_q <= 1'b0;
    else        s1_round_q <= s1_round_d;
  end
`else
`endif

  always_comb begin
`ifdef FLOAT_TO_EXP_INDEX_ROUND_EN
    mag_r = {1'b0, s1_mag_q} + {11'd0, s1_round_q};
`else
    mag_r = {1'b0, s1_mag_q};
`endif
    res_addr    = 12'd0;
    res_err     = 1'b0;
    res_inexact = s1_inexact_q;
    // Stage 2: bias, clamp to the table range 1..254, Inf/NaN maps to 0.
    if (s1_nan_q) begin
      res_err     = 1'b1;
      res_inexact = 1'b0;
    end else if (!s1_sign_q) begin
      if (mag_r > 12'd127) begin
        res_addr = 12'd254;
        res_err  = 1'b1;
      end else begin
        res_addr = mag_r + 12'd127;
      end
    end else begin
      if (mag_r > 12'd126) begin
        res_addr = 12'd1;
        res_err  = 1'b1;
      end else begin
        res_addr = 12'd127 - mag_r;
      end
    end
  end

  always_comb begin
    s1_valid_d    = en ? in_valid     : s1_valid_q;
    s1_sign_d     = en ? in_data[31]  : s1_sign_q;
    s1_nan_d      = en ? dec_nan      : s1_nan_q;
    s1_inexact_d  = en ? dec_inexact  : s1_inexact_q;
    s1_mag_d      = en ? dec_mag      : s1_mag_q;
    out_valid_d   = en ? s1_valid_q   : out_valid_q;
    out_addr_d    = en ? res_addr     : out_addr_q;
    out_err_d     = en ? res_err      : out_err_q;
    out_inexact_d = en ? res_inexact  : out_inexact_q;
    err_cnt_d     = err_cnt_q;
    if (out_valid_q && out_ready && out_err_q && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_nan_q      <= 1'b0;
      s1_inexact_q  <= 1'b0;
      s1_mag_q      <= 11'd0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= 12'd0;
      out_err_q     <= 1'b0;
      out_inexact_q <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_nan_q      <= s1_nan_d;
      s1_inexact_q  <= s1_inexact_d;
      s1_mag_q      <= s1_mag_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_err_q     <= out_err_d;
      out_inexact_q <= out_inexact_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign in_ready    = en;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_err     = out_err_q;
  assign out_inexact = out_inexact_q;
  assign err_cnt     = err_cnt_q;

endmodule
